axil_addr_decoder: RTL and testbench
====================================

# axil_addr_decoder

Single-master to SLAVE_NUM-slave AXI4-Lite address decoder and router. It sits between the PS/master AXI-Lite port and the peripheral register blocks, and routes each transaction by the top-level address map: slave i owns 0x43c0_0000 + i·0x1_0000 through 0x43c0_ffff + i·0x1_0000. The write and read paths are independent, and each allows one outstanding transaction. Unmapped addresses are answered locally with DECERR.

## Interface
Parameters:
- SLAVE_NUM, 4, number of downstream slaves
- ADDR_WIDTH, 32, AXI-Lite address width
- DATA_WIDTH, 32, AXI-Lite data width; strobe width is DATA_WIDTH/8
- SLAVE_LOW_ADDR, top_pkg value, [SLAVE_NUM][ADDR_WIDTH] inclusive region base per slave
- SLAVE_HIGH_ADDR, top_pkg value, [SLAVE_NUM][ADDR_WIDTH] inclusive region top per slave

Ports:
- Clocking and reset. One clock; reset is synchronous and active-high.
  - clk_i  in  1  system clock
  - rst_i  in  1  synchronous, active-high reset
- Master side (slave port), AXI-Lite:
  - s_aw*  AW channel: awaddr[ADDR_WIDTH] in, awvalid in, awready out
  - s_w*  W channel: wdata[DATA_WIDTH] in, wstrb[DATA_WIDTH/8] in, wvalid in, wready out
  - s_b*  B channel: bresp[2] out, bvalid out, bready in
  - s_ar*  AR channel: araddr[ADDR_WIDTH] in, arvalid in, arready out
  - s_r*  R channel: rdata[DATA_WIDTH] out, rresp[2] out, rvalid out, rready in
- Slave side (master ports): the same five channels with directions reversed.
  - Each signal is an array indexed [SLAVE_NUM].
  - Naming: m_awaddr, m_awvalid, m_awready, …, m_rready.

## Operation
Decode:
- hit[i] = (addr ≥ SLAVE_LOW_ADDR[i]) && (addr ≤ SLAVE_HIGH_ADDR[i]).
- If regions overlap, the lowest index wins.
- No hit means unmapped.

Write FSM (states W_IDLE, W_ADDR, W_FWD, W_RESP):
- W_IDLE:
  - s_awready=1 and s_wready=1.
  - AW and W are captured independently and may arrive in either order.
  - Once both are held, go to W_FWD on a hit, or to W_RESP with bresp=DECERR (2'b11) when unmapped.
- W_ADDR: W_IDLE sub-state in which one of AW/W is held. The ready of the held channel drops to 0.
- W_FWD:
  - Drive m_awvalid[sel] and m_wvalid[sel] with the latched addr/data/strb.
  - Each valid drops independently after its own handshake.
  - Once m_bvalid[sel] is seen, m_bready[sel] is pulsed for 1 cycle and bresp is latched.
  - Then go to W_RESP.
- W_RESP: s_bvalid=1 with the latched bresp until s_bready, then return to W_IDLE.

Read FSM (states R_IDLE, R_FWD, R_RESP):
- R_IDLE: s_arready=1. On handshake, latch araddr and decode.
- R_FWD:
  - m_arvalid[sel] is held until handshake.
  - m_rready[sel]=1 until m_rvalid[sel]; rdata and rresp are latched on that cycle.
- R_RESP: s_rvalid held until s_rready.
- Unmapped reads skip R_FWD and respond with rdata=0, rresp=DECERR.

Unselected outputs:
- Slave-side valid/ready outputs not currently selected are 0.
- m_* data/addr outputs are broadcast from the latched registers.

## Timing
Reset values:
- All s_*valid, m_*valid and m_*ready are 0.
- s_awready, s_wready and s_arready are 0 during reset and go to 1 in the first cycle after reset deasserts.
- Latched resp and rdata are 0.

Latency:
- The last of AW/W is accepted in cycle N; m_awvalid/m_wvalid rise in cycle N+1.
- m_bvalid is seen in cycle M; s_bvalid rises in cycle M+1.
- Reads follow the same pattern: AR in N, m_arvalid in N+1; m_rvalid in M, s_rvalid in M+1.
- Unmapped: response valid in cycle N+1.

Handshake rules:
- Valids never depend combinationally on the same-channel ready.
- Once asserted, a valid holds with stable payload until its handshake.

Concurrency:
- Reads and writes proceed concurrently, including to the same slave.
- No ordering between read and write paths is guaranteed.

Reset mid-transaction:
- All FSMs return to idle and all valids drop in the next cycle.
- The in-flight transaction is abandoned; no response is issued.

## Structure
- top_pkg additions:
  - axil_resp_t enum: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - Write and read FSM state enums.
- Sub-module: axil_addr_match, a combinational decoder.
  - Inputs: addr, region tables.
  - Outputs: sel index [$clog2(SLAVE_NUM)] and hit flag.
  - One instance each for the AW and AR paths.

## Test plan
1. **Mapped write, OKAY.** Write 0xDEAD_BEEF to 0x43c1_0004 with strb 0xF, AW and W in the same cycle.
   - Only slave 1 sees awaddr 0x43c1_0004 and wdata 0xDEAD_BEEF.
   - Slave returns OKAY; s_bresp=00 one cycle after m_bvalid.
2. **Unmapped read, DECERR.** Read 0x4000_0000.
   - No m_arvalid asserted.
   - s_rvalid in cycle N+1 with rdata=0, rresp=11.
3. **W before AW.** W is presented 3 cycles before AW to 0x43c3_0000.
   - s_wready drops after the W capture.
   - Slave 3 receives the correct wdata.
   - Exactly one B response.
4. **B backpressure.** s_bready held low for 10 cycles with slave 2 returning SLVERR.
   - s_bvalid stays high with bresp=10.
   - s_awready stays 0 until the B handshake.
5. **Concurrent read and write.** Read slave 0 at 0x43c0_0010 and write slave 3 in the same cycle.
   - Both complete with correct routing and no cross-talk between paths.
6. **Reset mid-transaction.** Assert rst_i while in W_FWD with m_awvalid[1]=1.
   - Next cycle all valids are 0.
   - After release, a new write to slave 0 completes normally.

Source files
------------

// File: rtl/top_pkg.sv
// Shared types and the default address map for the AXI4-Lite address decoder.
package top_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_FWD,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FWD,
        R_RESP
    } rd_state_t;

    localparam int DEFAULT_SLAVE_NUM  = 4;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    // Slave i owns one 64 KiB window starting at 0x43c0_0000 + i*0x1_0000
    localparam logic [DEFAULT_SLAVE_NUM-1:0][DEFAULT_ADDR_WIDTH-1:0] DEFAULT_LOW_ADDR = {
        32'h43c3_0000, 32'h43c2_0000, 32'h43c1_0000, 32'h43c0_0000
    };
    localparam logic [DEFAULT_SLAVE_NUM-1:0][DEFAULT_ADDR_WIDTH-1:0] DEFAULT_HIGH_ADDR = {
        32'h43c3_ffff, 32'h43c2_ffff, 32'h43c1_ffff, 32'h43c0_ffff
    };

endpackage

// File: rtl/axil_addr_match.sv
// Combinational region decoder: returns the lowest-indexed region containing addr.
module axil_addr_match #(
    parameter int SLAVE_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = 2
) (
    input  logic [ADDR_WIDTH-1:0]                addr,
    input  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] low_addr,
    input  logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] high_addr,
    output logic [SEL_WIDTH-1:0]                 sel,
    output logic                                 hit
);

    // Scan from the top so the lowest matching index is written last and wins on overlap
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if ((addr >= low_addr[i]) && (addr <= high_addr[i])) begin
                hit = 1'b1;
                sel = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/axil_addr_decoder.sv
// Single-master to SLAVE_NUM-slave AXI4-Lite router; independent write and read paths.
module axil_addr_decoder
    import top_pkg::*;
#(
    parameter int SLAVE_NUM  = DEFAULT_SLAVE_NUM,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_LOW_ADDR  = DEFAULT_LOW_ADDR,
    parameter logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0] SLAVE_HIGH_ADDR = DEFAULT_HIGH_ADDR
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,

    input  logic [ADDR_WIDTH-1:0]                 s_awaddr,
    input  logic                                  s_awvalid,
    output logic                                  s_awready,
    input  logic [DATA_WIDTH-1:0]                 s_wdata,
    input  logic [DATA_WIDTH/8-1:0]               s_wstrb,
    input  logic                                  s_wvalid,
    output logic                                  s_wready,
    output logic [1:0]                            s_bresp,
    output logic                                  s_bvalid,
    input  logic                                  s_bready,
    input  logic [ADDR_WIDTH-1:0]                 s_araddr,
    input  logic                                  s_arvalid,
    output logic                                  s_arready,
    output logic [DATA_WIDTH-1:0]                 s_rdata,
    output logic [1:0]                            s_rresp,
    output logic                                  s_rvalid,
    input  logic                                  s_rready,

    output logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]  m_awaddr,
    output logic [SLAVE_NUM-1:0]                  m_awvalid,
    input  logic [SLAVE_NUM-1:0]                  m_awready,
    output logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]  m_wdata,
    output logic [SLAVE_NUM-1:0][DATA_WIDTH/8-1:0] m_wstrb,
    output logic [SLAVE_NUM-1:0]                  m_wvalid,
    input  logic [SLAVE_NUM-1:0]                  m_wready,
    input  logic [SLAVE_NUM-1:0][1:0]             m_bresp,
    input  logic [SLAVE_NUM-1:0]                  m_bvalid,
    output logic [SLAVE_NUM-1:0]                  m_bready,
    output logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]  m_araddr,
    output logic [SLAVE_NUM-1:0]                  m_arvalid,
    input  logic [SLAVE_NUM-1:0]                  m_arready,
    input  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0]  m_rdata,
    input  logic [SLAVE_NUM-1:0][1:0]             m_rresp,
    input  logic [SLAVE_NUM-1:0]                  m_rvalid,
    output logic [SLAVE_NUM-1:0]                  m_rready
);

    localparam int SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

    // ---------------- write path ----------------
    wr_state_t               w_state, w_state_next;
    logic                    aw_held, w_held, aw_pend, w_pend;
    logic [ADDR_WIDTH-1:0]   awaddr_q, aw_dec_addr;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [SEL_W-1:0]        w_sel_q, aw_sel;
    logic                    aw_hit, aw_fire, w_fire, aw_have, w_have;
    axil_resp_t              bresp_q;

    assign aw_fire     = s_awvalid && s_awready;
    assign w_fire      = s_wvalid && s_wready;
    assign aw_have     = aw_held || aw_fire;
    assign w_have      = w_held || w_fire;
    // Decode the incoming address directly so forwarding starts the cycle after capture
    assign aw_dec_addr = aw_held ? awaddr_q : s_awaddr;

    axil_addr_match #(
        .SLAVE_NUM (SLAVE_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .SEL_WIDTH (SEL_W)
    ) u_aw_match (
        .addr     (aw_dec_addr),
        .low_addr (SLAVE_LOW_ADDR),
        .high_addr(SLAVE_HIGH_ADDR),
        .sel      (aw_sel),
        .hit      (aw_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) w_state <= W_IDLE;
        else       w_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE, W_ADDR: begin
                if (aw_have && w_have)      w_state_next = aw_hit ? W_FWD : W_RESP;
                else if (aw_have || w_have) w_state_next = W_ADDR;
            end
            W_FWD:   if (m_bvalid[w_sel_q]) w_state_next = W_RESP;
            W_RESP:  if (s_bready)          w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        case (w_state)
            W_IDLE, W_ADDR: begin
                s_awready = !rst_i && !aw_held;
                s_wready  = !rst_i && !w_held;
            end
            W_FWD: begin
                m_awvalid[w_sel_q] = aw_pend;
                m_wvalid[w_sel_q]  = w_pend;
                m_bready[w_sel_q]  = m_bvalid[w_sel_q];
            end
            W_RESP:  s_bvalid = 1'b1;
            default: ;
        endcase
    end

    // NOTE: payload registers are reset too, so the broadcast m_* buses never carry X.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            w_sel_q  <= '0;
            bresp_q  <= OKAY;
        end else begin
            if (aw_fire) awaddr_q <= s_awaddr;
            if (w_fire) begin
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            case (w_state)
                W_IDLE, W_ADDR: begin
                    if (aw_have && w_have) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        w_sel_q <= aw_sel;
                        aw_pend <= aw_hit;
                        w_pend  <= aw_hit;
                        if (!aw_hit) bresp_q <= DECERR;
                    end else begin
                        aw_held <= aw_have;
                        w_held  <= w_have;
                    end
                end
                W_FWD: begin
                    if (m_awready[w_sel_q]) aw_pend <= 1'b0;
                    if (m_wready[w_sel_q])  w_pend  <= 1'b0;
                    if (m_bvalid[w_sel_q]) begin
                        bresp_q <= axil_resp_t'(m_bresp[w_sel_q]);
                        aw_pend <= 1'b0;
                        w_pend  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_bresp  = bresp_q;
    assign m_awaddr = {SLAVE_NUM{awaddr_q}};
    assign m_wdata  = {SLAVE_NUM{wdata_q}};
    assign m_wstrb  = {SLAVE_NUM{wstrb_q}};

    // ---------------- read path ----------------
    rd_state_t             r_state, r_state_next;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    axil_resp_t            rresp_q;
    logic [SEL_W-1:0]      r_sel_q, ar_sel;
    logic                  ar_hit, ar_fire, ar_pend;

    assign ar_fire = s_arvalid && s_arready;

    axil_addr_match #(
        .SLAVE_NUM (SLAVE_NUM),
        .ADDR_WIDTH(ADDR_WIDTH),
        .SEL_WIDTH (SEL_W)
    ) u_ar_match (
        .addr     (s_araddr),
        .low_addr (SLAVE_LOW_ADDR),
        .high_addr(SLAVE_HIGH_ADDR),
        .sel      (ar_sel),
        .hit      (ar_hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= R_IDLE;
        else       r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire)           r_state_next = ar_hit ? R_FWD : R_RESP;
            R_FWD:   if (m_rvalid[r_sel_q]) r_state_next = R_RESP;
            R_RESP:  if (s_rready)          r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        case (r_state)
            R_IDLE: s_arready = !rst_i;
            R_FWD: begin
                m_arvalid[r_sel_q] = ar_pend;
                m_rready[r_sel_q]  = 1'b1;
            end
            R_RESP:  s_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            araddr_q <= '0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            r_sel_q  <= '0;
            ar_pend  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        araddr_q <= s_araddr;
                        r_sel_q  <= ar_sel;
                        ar_pend  <= ar_hit;
                        if (!ar_hit) begin
                            rdata_q <= '0;
                            rresp_q <= DECERR;
                        end
                    end
                end
                R_FWD: begin
                    if (m_arready[r_sel_q]) ar_pend <= 1'b0;
                    if (m_rvalid[r_sel_q]) begin
                        rdata_q <= m_rdata[r_sel_q];
                        rresp_q <= axil_resp_t'(m_rresp[r_sel_q]);
                        ar_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign m_araddr = {SLAVE_NUM{araddr_q}};

endmodule

// File: tb/tb_axil_addr_decoder.sv
// Directed cycle-exact bench for axil_addr_decoder with hand-computed expectations.
module tb_axil_addr_decoder;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]        s_wstrb;
    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]        s_bresp, s_rresp;
    logic [3:0][31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0][3:0]   m_wstrb;
    logic [3:0][1:0]   m_bresp, m_rresp;
    logic [3:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]        m_arvalid, m_arready, m_rvalid, m_rready;

    int n_checks = 0;
    int n_pass   = 0;

    axil_addr_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_slaves();
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0;
        m_arready = '0; m_rvalid = '0; m_rdata  = '0; m_rresp = '0;
    endtask

    // Present AW and W together for one cycle
    task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata  = data; s_wstrb   = strb; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        clr_slaves();

        // ---- reset state ----
        tick(); tick();
        check("rst_awready", 32'(s_awready), 32'h0);
        check("rst_arready", 32'(s_arready), 32'h0);
        check("rst_valids",  32'({s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}), 32'h0);
        check("rst_readys",  32'({m_bready, m_rready}), 32'h0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 32'({s_awready, s_wready, s_arready}), 32'h7);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_resp",  32'({s_bresp, s_rresp}), 32'h0);

        // ---- 1: mapped write to slave 1, OKAY ----
        send_write(32'h43c1_0004, 32'hDEAD_BEEF, 4'hF);
        check("t1_awvalid", 32'(m_awvalid), 32'h2);
        check("t1_wvalid",  32'(m_wvalid), 32'h2);
        check("t1_awaddr",  m_awaddr[1], 32'h43c1_0004);
        check("t1_wdata",   m_wdata[1], 32'hDEAD_BEEF);
        check("t1_wstrb",   32'(m_wstrb[1]), 32'hF);
        check("t1_awready_busy", 32'(s_awready), 32'h0);
        m_awready = 4'h2; m_wready = 4'h2;
        tick();
        clr_slaves();
        check("t1_valids_drop", 32'({m_awvalid, m_wvalid}), 32'h0);
        m_bvalid = 4'h2; m_bresp[1] = 2'b00;
        #1;
        check("t1_bready", 32'(m_bready), 32'h2);
        check("t1_no_early_b", 32'(s_bvalid), 32'h0);
        tick();
        clr_slaves();
        check("t1_bvalid", 32'(s_bvalid), 32'h1);
        check("t1_bresp",  32'(s_bresp), 32'h0);
        check("t1_bready_pulse", 32'(m_bready), 32'h0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("t1_b_done", 32'(s_bvalid), 32'h0);

        // ---- 3: W three cycles before AW to slave 3 ----
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hC; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("t3_wready_drop", 32'(s_wready), 32'h0);
        check("t3_awready_open", 32'(s_awready), 32'h1);
        tick(); tick();
        s_awaddr = 32'h43c3_0000; s_awvalid = 1'b1;
        #1;
        check("t3_wready_held", 32'(s_wready), 32'h0);
        tick();
        s_awvalid = 1'b0;
        check("t3_awvalid", 32'(m_awvalid), 32'h8);
        check("t3_wvalid",  32'(m_wvalid), 32'h8);
        check("t3_wdata",   m_wdata[3], 32'hCAFE_F00D);
        check("t3_wstrb",   32'(m_wstrb[3]), 32'hC);
        check("t3_awaddr",  m_awaddr[3], 32'h43c3_0000);
        m_awready = 4'h8;
        tick();
        clr_slaves();
        check("t3_aw_only_drop", 32'({m_awvalid, m_wvalid}), 32'h08);
        m_wready = 4'h8;
        tick();
        clr_slaves();
        check("t3_w_drop", 32'(m_wvalid), 32'h0);
        m_bvalid = 4'h8;
        tick();
        clr_slaves();
        check("t3_bvalid", 32'(s_bvalid), 32'h1);
        s_bready = 1'b1;
        tick();
        check("t3_b_done", 32'(s_bvalid), 32'h0);
        tick();
        s_bready = 1'b0;
        check("t3_single_b", 32'(s_bvalid), 32'h0);

        // ---- 4: B backpressure with SLVERR from slave 2 ----
        send_write(32'h43c2_0008, 32'h1234_5678, 4'hF);
        check("t4_awvalid", 32'(m_awvalid), 32'h4);
        m_awready = 4'h4; m_wready = 4'h4;
        tick();
        clr_slaves();
        m_bvalid = 4'h4; m_bresp[2] = 2'b10;
        tick();
        clr_slaves();
        for (int i = 0; i < 10; i++) begin
            check("t4_bp_bvalid",  32'(s_bvalid), 32'h1);
            check("t4_bp_bresp",   32'(s_bresp), 32'h2);
            check("t4_bp_awready", 32'(s_awready), 32'h0);
            tick();
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("t4_b_done", 32'(s_bvalid), 32'h0);
        check("t4_awready_back", 32'(s_awready), 32'h1);

        // ---- 5: concurrent read of slave 0 and write to slave 3 ----
        s_araddr = 32'h43c0_0010; s_arvalid = 1'b1;
        send_write(32'h43c3_0020, 32'hAAAA_5555, 4'hF);
        s_arvalid = 1'b0;
        check("t5_arvalid", 32'(m_arvalid), 32'h1);
        check("t5_rready",  32'(m_rready), 32'h1);
        check("t5_araddr",  m_araddr[0], 32'h43c0_0010);
        check("t5_awvalid", 32'(m_awvalid), 32'h8);
        check("t5_wvalid",  32'(m_wvalid), 32'h8);
        check("t5_wdata",   m_wdata[3], 32'hAAAA_5555);
        m_arready = 4'h1; m_awready = 4'h8; m_wready = 4'h8;
        tick();
        clr_slaves();
        check("t5_req_drop", 32'({m_arvalid, m_awvalid, m_wvalid}), 32'h0);
        m_rvalid = 4'h1; m_rdata[0] = 32'h0BAD_F00D; m_rresp[0] = 2'b00;
        m_bvalid = 4'h8; m_bresp[3] = 2'b00;
        tick();
        clr_slaves();
        check("t5_rvalid", 32'(s_rvalid), 32'h1);
        check("t5_rdata",  s_rdata, 32'h0BAD_F00D);
        check("t5_rresp",  32'(s_rresp), 32'h0);
        check("t5_bvalid", 32'(s_bvalid), 32'h1);
        check("t5_bresp",  32'(s_bresp), 32'h0);
        s_rready = 1'b1; s_bready = 1'b1;
        tick();
        s_rready = 1'b0; s_bready = 1'b0;
        check("t5_done", 32'({s_rvalid, s_bvalid}), 32'h0);

        // ---- 2: unmapped read answers DECERR locally ----
        s_araddr = 32'h4000_0000; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("t2_no_arvalid", 32'(m_arvalid), 32'h0);
        check("t2_rvalid", 32'(s_rvalid), 32'h1);
        check("t2_rdata",  s_rdata, 32'h0);
        check("t2_rresp",  32'(s_rresp), 32'h3);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("t2_done", 32'(s_rvalid), 32'h0);

        // unmapped write completes with DECERR one cycle after capture
        send_write(32'h5000_0000, 32'h1, 4'h1);
        check("uw_no_awvalid", 32'({m_awvalid, m_wvalid}), 32'h0);
        check("uw_bvalid", 32'(s_bvalid), 32'h1);
        check("uw_bresp",  32'(s_bresp), 32'h3);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;

        // ---- 6: reset while forwarding to slave 1 ----
        send_write(32'h43c1_0000, 32'h7777_0000, 4'hF);
        check("t6_fwd", 32'(m_awvalid), 32'h2);
        rst_i = 1'b1;
        tick();
        check("t6_rst_valids", 32'({m_awvalid, m_wvalid, s_bvalid, s_rvalid}), 32'h0);
        check("t6_rst_ready",  32'(s_awready), 32'h0);
        rst_i = 1'b0;
        #1;
        check("t6_ready_back", 32'({s_awready, s_wready}), 32'h3);
        send_write(32'h43c0_0004, 32'h5A5A_5A5A, 4'h3);
        check("t6_awvalid", 32'(m_awvalid), 32'h1);
        check("t6_awaddr",  m_awaddr[0], 32'h43c0_0004);
        check("t6_wdata",   m_wdata[0], 32'h5A5A_5A5A);
        m_awready = 4'h1; m_wready = 4'h1;
        tick();
        clr_slaves();
        m_bvalid = 4'h1;
        tick();
        clr_slaves();
        check("t6_bvalid", 32'(s_bvalid), 32'h1);
        check("t6_bresp",  32'(s_bresp), 32'h0);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("t6_done", 32'(s_bvalid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
